stm_register_reader: RTL and testbench
======================================

Name: stm_register_reader

Overview:
- Store-multiple (ARM STM) sequencer: the read-side client of the 16x32 register file.
- Takes a 16-bit register list, base address and addressing mode; walks the list lowest-to-highest, driving the register file's read address and capturing the 32-bit read data.
- Streams {address, data} words to the memory-write interface under a valid/ready handshake, then reports the written-back base value.
- Sits between instruction decode/control and the data-memory port.

Parameters:
- DATA_W, 32, register/memory data width
- ADDR_W, 32, memory address width
- WORD_BYTES, 4, address stride per transferred register

Ports:
- CLK  in  1  system clock, rising-edge
- CLR  in  1  asynchronous active-low reset (0 = clear)
- start  in  1  request; accepted only in IDLE
- regList  in  16  bit i set = store Ri; sampled on accepted start
- baseAddr  in  ADDR_W  base register value; sampled on accepted start
- upDown  in  1  U bit: 1 = increment, 0 = decrement
- preIndex  in  1  P bit: 1 = before, 0 = after
- regAddr  out  4  register file read address (port B)
- regData  in  DATA_W  register file read data (combinational from regAddr)
- memAddr  out  ADDR_W  byte address of current word
- memData  out  DATA_W  data of current word
- memValid  out  1  word valid
- memReady  in  1  memory accepts word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last word is accepted
- finalBase  out  ADDR_W  base writeback value; held from done until the next accepted start

Behaviour:
- Reset (CLR=0, async): state IDLE; regAddr, memAddr, memData, finalBase = 0; memValid, busy, done = 0; internal list cleared.
- States: IDLE, LOAD, SEND, FIN.
- IDLE:
  - start=1 captures regList, baseAddr, upDown, preIndex; n = popcount(regList); next state LOAD.
  - If regList = 0, go to FIN instead (no transfers; finalBase = baseAddr).
- Start address (lowest register always at lowest address):
  - IA: base
  - IB: base+4
  - DA: base-4n+4
  - DB: base-4n
- finalBase = base+4n if upDown=1, else base-4n. Computed on the start cycle; arithmetic is modulo 2^ADDR_W.
- LOAD (1 cycle):
  - regAddr = index of the lowest set bit in the remaining list.
  - At the clock edge: memData <= regData; memAddr <= current address; that bit is cleared; next state SEND.
- SEND:
  - memValid=1; memAddr and memData are held stable until memReady=1.
  - On the memReady=1 edge: current address += WORD_BYTES.
  - Next state is LOAD if the remaining list is nonzero, else FIN.
- FIN (1 cycle): done=1; next state IDLE.
- Latency:
  - Minimum 2 cycles per register, plus 1 (start accepted) and 1 (FIN).
  - Full list with memReady tied high: done asserts 34 cycles after the start edge.
- start while busy is ignored. regList/baseAddr changes while busy have no effect.
- memReady while memValid=0 is ignored.
- CLR asserted mid-transfer: immediate return to IDLE; memValid drops; no done pulse.
- regAddr holds its last value outside LOAD.

Optional Feature:
- STM_PC_OFFSET_EN defined: when the register being stored is R15, memData <= regData + 8, modelling pipelined PC store semantics.
- Undefined: R15 is stored unmodified, like every other register.

Decomposition:
- Shared package (stm_pkg): state encoding localparams (IDLE, LOAD, SEND, FIN), addressing mode constants {P,U} (MODE_DA=00, MODE_IA=01, MODE_DB=10, MODE_IB=11), WORD_BYTES.
- One sub-module: lowest_set_bit_16. Combinational; takes a 16-bit vector; outputs the 4-bit index of the lowest set bit, the vector with that bit cleared, and a zero flag. It is used for regAddr sequencing.
- Popcount stays inline.

Test Plan:
- IA, list 0x000B, base 0x1000, memReady=1, R0/R1/R3 = 0xA/0xB/0xD:
  - words (0x1000,0xA), (0x1004,0xB), (0x1008,0xD)
  - finalBase 0x100C
  - done 8 cycles after start
- DB, list 0x8001, base 0x2000:
  - words (0x1FF8,R0), (0x1FFC,R15)
  - finalBase 0x1FF8
  - with STM_PC_OFFSET_EN, the R15 word is R15+8
- IB, list 0x0004, base 0x100, memReady low for 5 cycles:
  - memValid stays high; memAddr=0x104 and memData stable throughout
  - one word only, accepted on the first ready edge
- Empty list, base 0x300:
  - no memValid
  - done 2 cycles after start; finalBase 0x300
- CLR pulsed low during the second SEND of a 4-register list:
  - all outputs 0 immediately
  - a subsequent start runs correctly from IDLE
- start held high through the whole operation: exactly one operation runs. start=1 while busy: captured values unchanged.

Source files
------------

// File: rtl/stm_pkg.sv
// Shared definitions for the store-multiple sequencer: FSM state encoding,
// {P,U} addressing-mode codes and the per-register address stride.
package stm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Addressing mode as {preIndex, upDown}
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/lowest_set_bit_16.sv
// Combinational lowest-set-bit finder for a 16-bit register list: gives the
// index of the lowest set bit, the list with that bit removed, and a flag
// that is high when the list is empty (index is then 0).
module lowest_set_bit_16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic [15:0] cleared,
  output logic        zero
);

  // Scan from the top down so the last hit is the lowest set bit
  always_comb begin
    // NOTE: combinational logic uses blocking assignments, and every output
    // gets a default before any conditional code so no latch is inferred.
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    cleared = vec & (vec - 16'd1);
    zero    = (vec == 16'd0);
  end

endmodule

// File: rtl/stm_register_reader.sv
// Store-multiple (STM) sequencer: walks a 16-bit register list from lowest
// to highest register, reads each register through the register-file read
// port and streams {address, data} words to memory under valid/ready.
// Optional build macro: STM_PC_OFFSET_EN -- R15 is stored as its value + 8.
module stm_register_reader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = stm_pkg::WORD_BYTES
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [15:0]       regList,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic              upDown,
  input  logic              preIndex,
  output logic [3:0]        regAddr,
  input  logic [DATA_W-1:0] regData,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memData,
  output logic              memValid,
  input  logic              memReady,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] finalBase
);

  import stm_pkg::*;

  state_t              state_q, state_d;
  logic [15:0]         list_q, list_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [3:0]          reg_addr_q, reg_addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [ADDR_W-1:0]   final_base_q, final_base_d;

  logic [15:0]         lsb_in;
  logic [3:0]          lsb_idx;
  logic [15:0]         lsb_cleared;
  logic                lsb_zero;

  logic [4:0]          pop_cnt;
  logic [ADDR_W-1:0]   stride;
  logic [ADDR_W-1:0]   span;
  logic [ADDR_W-1:0]   start_addr;
  logic [DATA_W-1:0]   load_data;
  logic                accept;

  // In IDLE the finder looks at the incoming list so the first register
  // index is ready on the start edge; otherwise it tracks the remaining list.
  assign lsb_in = (state_q == IDLE) ? regList : list_q;

  lowest_set_bit_16 u_lsb (
    .vec     (lsb_in),
    .idx     (lsb_idx),
    .cleared (lsb_cleared),
    .zero    (lsb_zero)
  );

  // A word leaves only while it is actually being offered
  assign accept = (state_q == SEND) && memReady;

  // Transfer count and address arithmetic for the start cycle
  always_comb begin
    pop_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      pop_cnt = pop_cnt + 5'(regList[i]);
    end
    stride = ADDR_W'(WORD_BYTES);
    span   = ADDR_W'(pop_cnt) * stride;
    start_addr = baseAddr;
    case ({preIndex, upDown})
      MODE_IA: start_addr = baseAddr;
      MODE_IB: start_addr = baseAddr + stride;
      MODE_DA: start_addr = baseAddr - span + stride;
      MODE_DB: start_addr = baseAddr - span;
    endcase
  end

  // Data captured from the register file, with optional PC adjustment
  always_comb begin
`ifdef STM_PC_OFFSET_EN
    load_data = (reg_addr_q == 4'd15) ? regData + DATA_W'(8) : regData;
`else
    load_data = regData;
`endif
  end

  // State register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)  state_d = lsb_zero ? FIN : LOAD;
      LOAD:             state_d = SEND;
      SEND: if (accept) state_d = lsb_zero ? FIN : LOAD;
      FIN:              state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Datapath next values: capture on start, load on LOAD, advance on accept
  always_comb begin
    list_d       = list_q;
    cur_addr_d   = cur_addr_q;
    reg_addr_d   = reg_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    final_base_d = final_base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          list_d       = regList;
          cur_addr_d   = start_addr;
          final_base_d = upDown ? baseAddr + span : baseAddr - span;
          if (!lsb_zero) reg_addr_d = lsb_idx;
        end
      end
      LOAD: begin
        mem_data_d = load_data;
        mem_addr_d = cur_addr_q;
        list_d     = lsb_cleared;
      end
      SEND: begin
        if (accept) begin
          cur_addr_d = cur_addr_q + stride;
          if (!lsb_zero) reg_addr_d = lsb_idx;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge CLR) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    if (!CLR) begin
      list_q       <= '0;
      cur_addr_q   <= '0;
      reg_addr_q   <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      final_base_q <= '0;
    end else begin
      list_q       <= list_d;
      cur_addr_q   <= cur_addr_d;
      reg_addr_q   <= reg_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      final_base_q <= final_base_d;
    end
  end

  // Outputs decoded from state plus the held datapath registers
  always_comb begin
    memValid  = (state_q == SEND);
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    regAddr   = reg_addr_q;
    memAddr   = mem_addr_q;
    memData   = mem_data_q;
    finalBase = final_base_q;
  end

endmodule

// File: tb/tb_stm_register_reader.sv
// Self-checking bench for stm_register_reader: a register-file model drives
// regData, expected memory words are queued when an operation is started and
// popped as the DUT hands them over.
module tb_stm_register_reader;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        start = 1'b0;
  logic [15:0] regList = '0;
  logic [31:0] baseAddr = '0;
  logic        upDown = 1'b0;
  logic        preIndex = 1'b0;
  logic [3:0]  regAddr;
  logic [31:0] regData;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        memValid;
  logic        memReady = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] finalBase;

  logic [31:0] rf [16];
  logic [63:0] exp_q [$];

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  assign regData = rf[regAddr];

  stm_register_reader dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .start     (start),
    .regList   (regList),
    .baseAddr  (baseAddr),
    .upDown    (upDown),
    .preIndex  (preIndex),
    .regAddr   (regAddr),
    .regData   (regData),
    .memAddr   (memAddr),
    .memData   (memData),
    .memValid  (memValid),
    .memReady  (memReady),
    .busy      (busy),
    .done      (done),
    .finalBase (finalBase)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stored_value(input int r);
`ifdef STM_PC_OFFSET_EN
    if (r == 15) return rf[r] + 32'd8;
`endif
    return rf[r];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, memValid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_regaddr"}, regAddr, 0);
    check({tag, "_memaddr"}, memAddr, 0);
    check({tag, "_memdata"}, memData, 0);
    check({tag, "_finalbase"}, finalBase, 0);
  endtask

  // One STM operation. stall: cycles memReady stays low while a word is
  // offered (applies to the first word). hold: keep start high and scramble
  // the list/base inputs while busy. clr_at: cycle at which CLR is pulsed.
  task automatic run_op(input logic [15:0] list, input logic [31:0] base,
                        input logic up, input logic pre, input int stall,
                        input logic hold, input int clr_at);
    logic [31:0] addr;
    logic [31:0] fbase;
    logic [31:0] span;
    int n;
    int exp_done;
    int stall_seen;
    bit finished;

    n    = $countones(list);
    span = 32'(4 * n);
    if (up) addr = pre ? base + 32'd4 : base;
    else    addr = pre ? base - span : base - span + 32'd4;
    for (int r = 0; r < 16; r++) begin
      if (list[r]) begin
        exp_q.push_back({addr, stored_value(r)});
        addr = addr + 32'd4;
      end
    end
    fbase    = up ? base + span : base - span;
    exp_done = 2 * n + 2 + stall;

    @(posedge CLK); #1;
    start    = 1'b1;
    regList  = list;
    baseAddr = base;
    upDown   = up;
    preIndex = pre;
    memReady = (stall == 0);
    stall_seen = 0;
    finished   = 0;

    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(negedge CLK);
      if (clr_at != 0 && cyc == clr_at) begin
        check("clr_pre_valid", memValid, 1);
        #2 CLR = 1'b0;
        #1 check_all_zero("clr");
        CLR = 1'b1;
        exp_q.delete();
        finished = 1;
      end else begin
        check("busy", busy, (cyc >= 2 && cyc <= exp_done));
        if (memValid) begin
          if (exp_q.size() == 0) begin
            check("extra_word", memValid, 0);
          end else if (memReady) begin
            check("word", {memAddr, memData}, exp_q.pop_front());
          end else begin
            check("stall_word", {memAddr, memData}, exp_q[0]);
            stall_seen++;
          end
        end
        if (done) begin
          check("done_cycle", cyc, exp_done);
          check("final_base", finalBase, fbase);
          check("words_left", exp_q.size(), 0);
          finished = 1;
        end else if (cyc == exp_done) begin
          check("done", done, 1);
        end
      end
      @(posedge CLK); #1;
      start = hold && !finished;
      if (hold && !finished) begin
        regList  = 16'($urandom);
        baseAddr = $urandom;
        upDown   = 1'($urandom);
        preIndex = 1'($urandom);
      end
      memReady = (stall_seen >= stall);
    end
    check("timeout", finished, 1);
    start = 1'b0;

    // Back in IDLE: nothing restarts and the writeback base is held
    if (clr_at == 0) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge CLK);
        check("idle_busy", busy, 0);
        check("held_base", finalBase, fbase);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rf[r] = 32'hC0DE_0000 + 32'(r * 32'h111);
    rf[0] = 32'hA;
    rf[1] = 32'hB;
    rf[3] = 32'hD;

    #12 check_all_zero("reset");
    @(negedge CLK);
    CLR = 1'b1;

    // IA, three registers, ready tied high
    run_op(16'h000B, 32'h1000, 1'b1, 1'b0, 0, 1'b0, 0);
    // DB with R0 and R15
    run_op(16'h8001, 32'h2000, 1'b0, 1'b1, 0, 1'b0, 0);
    // IB single register, memory stalls five cycles
    run_op(16'h0004, 32'h0100, 1'b1, 1'b1, 5, 1'b0, 0);
    // Empty list
    run_op(16'h0000, 32'h0300, 1'b1, 1'b0, 0, 1'b0, 0);
    // DA across the zero boundary
    run_op(16'h00F0, 32'h0000_0008, 1'b0, 1'b0, 0, 1'b0, 0);
    // DB wrapping below zero
    run_op(16'h000F, 32'h0000_0004, 1'b0, 1'b1, 0, 1'b0, 0);
    // Full list, done 34 cycles in
    run_op(16'hFFFF, 32'h4000, 1'b1, 1'b0, 0, 1'b0, 0);
    // Reset in the second SEND of a four-register list, then a clean rerun
    run_op(16'h0F00, 32'h5000, 1'b1, 1'b0, 0, 1'b0, 5);
    run_op(16'h0F00, 32'h5000, 1'b1, 1'b0, 0, 1'b0, 0);
    // start held high with inputs scrambled while busy
    run_op(16'h0A50, 32'h6000, 1'b0, 1'b0, 0, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
